// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display sharing one nibble-to-segment decoder.
//
// The block holds one nibble per digit and rotates through the digits. Each
// slot is REFRESH_DIV cycles long. The first BLANK_CYCLES cycles of a slot
// keep every anode off so the previous digit does not ghost. After that, the
// selected anode is driven low for the rest of the slot. Leading-zero
// blanking optionally keeps high-order zero digits dark.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wr_en      digit register file write strobe
//   wr_addr    digit index written (0 = least significant)
//   wr_data    nibble written
//   digit_en   per-digit display enable, sampled at slot start
//   lz_blank   leading-zero blanking enable, sampled at slot start
//   nibble     value presented to the shared decoder (bit 3 -> x, bit 0 -> w)
//   an_n       registered active-low anode enables
//   cur_digit  digit owning the current slot
//   slot_tick  one-cycle pulse in the first cycle of every slot except the
//              first slot after reset
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          lz_blank,
  output logic [3:0]                    nibble,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] cur_digit,
  output logic                          slot_tick
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [CW-1:0] CNT_MAX    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
  localparam logic [AW-1:0] LAST_DIGIT = AW'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            regs [NUM_DIGITS];
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         cur_q, cur_d;
  logic [3:0]            nibble_q, nibble_d;
  logic                  show_q, show_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  tick_q, tick_d;

  logic                  wrap;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] zero_from;  // zero_from[i]: regs[i..NUM_DIGITS-1] all zero
  logic                  suppress;

  // NOTE: always_comb gives every variable a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    wrap     = (cnt_q == CNT_MAX);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    cur_d    = cur_q;
    state_d  = state_q;
    nibble_d = nibble_q;
    show_d   = show_q;
    tick_d   = wrap;
    zero_run = 1'b1;
    zero_from = '0;

    if (wrap) begin
      cur_d = (cur_q == LAST_DIGIT) ? '0 : cur_q + 1'b1;
    end

    if (wrap) begin
      state_d = BLANK;
    end else if (cnt_d == BLANK_END) begin
      state_d = DRIVE;
    end

    // Scan from the top digit down: a digit is a leading zero only when it
    // and everything above it hold zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (regs[i] == 4'h0);
      zero_from[i] = zero_run;
    end
    suppress = lz_blank && (cur_d != '0) && zero_from[cur_d];

    // Slot-start latch uses register contents from before this edge, so a
    // write on the same edge only shows up on the digit's next visit.
    if (wrap) begin
      nibble_d = regs[cur_d];
      show_d   = digit_en[cur_d] & ~suppress;
    end

    // an_n is registered from the next-state values so it lines up exactly
    // with the BLANK/DRIVE phase of the counter.
    an_n_d = '1;
    if (state_d == DRIVE && show_d) begin
      an_n_d[cur_d] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      cur_q    <= '0;
      nibble_q <= 4'h0;
      show_q   <= 1'b0;
      an_n_q   <= '1;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      nibble_q <= nibble_d;
      show_q   <= show_d;
      an_n_q   <= an_n_d;
      tick_q   <= tick_d;
    end
  end

  // NOTE: the digit register file is reset, unlike a typical RAM, because
  // leading-zero blanking and the post-reset display read its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        regs[i] <= 4'h0;
      end
    end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign nibble    = nibble_q;
  assign an_n      = an_n_q;
  assign cur_digit = cur_q;
  assign slot_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. Inputs change and outputs are sampled on the falling edge.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] digit_en;
  logic       lz_blank;
  logic [3:0] nibble;
  logic [3:0] an_n;
  logic [1:0] cur_digit;
  logic       slot_tick;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .digit_en (digit_en),
    .lz_blank (lz_blank),
    .nibble   (nibble),
    .an_n     (an_n),
    .cur_digit(cur_digit),
    .slot_tick(slot_tick)
  );

  always #5 clk = ~clk;

  // What one 8-cycle slot looked like from the outside.
  typedef struct packed {
    logic [1:0] cur;
    logic [3:0] nib;
    logic [3:0] lead;      // leading cycles with all anodes off
    logic [3:0] drv;       // anode pattern after the blank phase (F if dark)
    logic       shape_ok;  // nibble/cur constant, drive pattern constant
    logic [3:0] ticks;     // slot_tick pulses seen inside the slot
    logic       next_tick; // slot_tick on the cycle after the slot
  } slot_obs_t;

  function automatic slot_obs_t exp_slot(input logic [1:0] c, input logic [3:0] n,
                                         input logic [3:0] d);
    slot_obs_t s;
    s.cur       = c;
    s.nib       = n;
    s.lead      = (d == 4'hF) ? 4'd8 : 4'd2;
    s.drv       = d;
    s.shape_ok  = 1'b1;
    s.ticks     = 4'd1;
    s.next_tick = 1'b1;
    return s;
  endfunction

  function automatic string fmt_slot(input slot_obs_t s);
    return $sformatf("cur=%0d nib=%h lead=%0d an_n=%b shape_ok=%b ticks=%0d next_tick=%b",
                     s.cur, s.nib, s.lead, s.drv, s.shape_ok, s.ticks, s.next_tick);
  endfunction

  // Records one slot starting at the current falling edge; returns one
  // falling edge past the slot, i.e. at the start of the following slot.
  task automatic capture_slot(output slot_obs_t s);
    logic seen = 1'b0;
    s.cur = cur_digit; s.nib = nibble; s.lead = 4'd0; s.drv = 4'hF;
    s.shape_ok = 1'b1; s.ticks = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (slot_tick) s.ticks = s.ticks + 4'd1;
      if (nibble !== s.nib || cur_digit !== s.cur) s.shape_ok = 1'b0;
      if (!seen && an_n === 4'hF) begin
        s.lead = s.lead + 4'd1;
      end else if (!seen) begin
        seen  = 1'b1;
        s.drv = an_n;
      end else if (an_n !== s.drv) begin
        s.shape_ok = 1'b0;
      end
    end
    @(negedge clk);
    s.next_tick = slot_tick;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Advance to the next slot start (optionally of a given digit), bounded.
  task automatic wait_slot(input logic [1:0] want, input logic any);
    logic found = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (slot_tick === 1'b1 && (any || cur_digit === want)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL slot_wait: no slot start for digit %0d within 64 cycles, required one", want);
    end
  endtask

  // Every-cycle invariants: one anode at most, nibble frozen while lit.
  logic [3:0] prev_nib = 4'h0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones(~an_n) > 1) begin
        errors++;
        $display("FAIL one_hot_anode: an_n=%b, required at most one low bit", an_n);
      end
      if (an_n !== 4'hF) begin
        checks++;
        if (nibble !== prev_nib) begin
          errors++;
          $display("FAIL nibble_stable: nibble=%h while lit, required %h", nibble, prev_nib);
        end
      end
    end
    prev_nib <= nibble;
  end

  task automatic test_reset;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0;
    digit_en = 4'b1111; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (an_n !== 4'hF || nibble !== 4'h0 || cur_digit !== 2'd0 || slot_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: an_n=%b nibble=%h cur=%0d tick=%b, required 1111 0 0 0",
               an_n, nibble, cur_digit, slot_tick);
    end
    rst_n = 1'b1;
    // First slot after release: digit 0, dark, no tick. Load 1,2,3,4 meanwhile.
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (an_n !== 4'hF || cur_digit !== 2'd0 || slot_tick !== 1'b0 || nibble !== 4'h0) begin
        errors++;
        $display("FAIL first_slot_dark k=%0d: an_n=%b cur=%0d tick=%b nib=%h, required 1111 0 0 0",
                 k, an_n, cur_digit, slot_tick, nibble);
      end
      wr_en   = (k < 4);
      wr_addr = 2'(3 - k);
      wr_data = 4'(k + 1);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_basic_scan;
    slot_obs_t e [4];
    slot_obs_t s;
    e[0] = exp_slot(2'd1, 4'h3, 4'b1101);
    e[1] = exp_slot(2'd2, 4'h2, 4'b1011);
    e[2] = exp_slot(2'd3, 4'h1, 4'b0111);
    e[3] = exp_slot(2'd0, 4'h4, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      capture_slot(s);
      checks++;
      if (s !== e[i]) begin
        errors++;
        $display("FAIL basic_scan slot %0d: got %s, required %s", i, fmt_slot(s), fmt_slot(e[i]));
      end
    end
  endtask

  task automatic test_lz_blank;
    slot_obs_t e [12];
    slot_obs_t s;
    // 0,0,0,7: only digit 0 lights.
    e[0]  = exp_slot(2'd2, 4'h0, 4'hF);
    e[1]  = exp_slot(2'd3, 4'h0, 4'hF);
    e[2]  = exp_slot(2'd0, 4'h7, 4'b1110);
    e[3]  = exp_slot(2'd1, 4'h0, 4'hF);
    // 0,5,0,0: digit 3 dark, inner zero on digit 1 shown.
    e[4]  = exp_slot(2'd3, 4'h0, 4'hF);
    e[5]  = exp_slot(2'd0, 4'h0, 4'b1110);
    e[6]  = exp_slot(2'd1, 4'h0, 4'b1101);
    e[7]  = exp_slot(2'd2, 4'h5, 4'b1011);
    // All zero: digit 0 still lights.
    e[8]  = exp_slot(2'd0, 4'h0, 4'b1110);
    e[9]  = exp_slot(2'd1, 4'h0, 4'hF);
    e[10] = exp_slot(2'd2, 4'h0, 4'hF);
    e[11] = exp_slot(2'd3, 4'h0, 4'hF);
    lz_blank = 1'b1;
    write_reg(2'd3, 4'h0); write_reg(2'd2, 4'h0);
    write_reg(2'd1, 4'h0); write_reg(2'd0, 4'h7);
    for (int i = 0; i < 12; i++) begin
      if (i == 0) wait_slot(2'd0, 1'b1);
      if (i == 4) begin write_reg(2'd2, 4'h5); write_reg(2'd0, 4'h0); wait_slot(2'd0, 1'b1); end
      if (i == 8) begin write_reg(2'd2, 4'h0); wait_slot(2'd0, 1'b1); end
      capture_slot(s);
      checks++;
      if (s !== e[i]) begin
        errors++;
        $display("FAIL lz_blank slot %0d: got %s, required %s", i, fmt_slot(s), fmt_slot(e[i]));
      end
      if (i == 3 || i == 7) begin
        // The capture ran one edge into the next slot; the writes below
        // land mid-slot and are picked up at the following slot start.
      end
    end
  endtask

  task automatic test_disabled_digit;
    slot_obs_t e [4];
    slot_obs_t s;
    e[0] = exp_slot(2'd1, 4'h3, 4'b1101);
    e[1] = exp_slot(2'd2, 4'h2, 4'hF);
    e[2] = exp_slot(2'd3, 4'h1, 4'b0111);
    e[3] = exp_slot(2'd0, 4'h4, 4'b1110);
    lz_blank = 1'b0;
    digit_en = 4'b1011;
    write_reg(2'd3, 4'h1); write_reg(2'd2, 4'h2);
    write_reg(2'd1, 4'h3); write_reg(2'd0, 4'h4);
    wait_slot(2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      capture_slot(s);
      checks++;
      if (s !== e[i]) begin
        errors++;
        $display("FAIL disabled_digit slot %0d: got %s, required %s", i, fmt_slot(s), fmt_slot(e[i]));
      end
    end
    digit_en = 4'b1111;
  endtask

  task automatic test_write_collision;
    slot_obs_t e [5];
    slot_obs_t s;
    e[0] = exp_slot(2'd1, 4'h2, 4'b1101);
    e[1] = exp_slot(2'd2, 4'h2, 4'b1011);
    e[2] = exp_slot(2'd3, 4'h1, 4'b0111);
    e[3] = exp_slot(2'd0, 4'h4, 4'b1110);
    e[4] = exp_slot(2'd1, 4'h9, 4'b1101);
    write_reg(2'd1, 4'h2);
    wait_slot(2'd0, 1'b0);
    repeat (7) @(negedge clk);
    // The next rising edge is both the digit-1 slot start and this write.
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h9;
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      capture_slot(s);
      checks++;
      if (s !== e[i]) begin
        errors++;
        $display("FAIL write_collision slot %0d: got %s, required %s", i, fmt_slot(s), fmt_slot(e[i]));
      end
    end
  endtask

  task automatic test_reset_mid_drive;
    slot_obs_t s;
    slot_obs_t e;
    repeat (4) @(negedge clk);
    checks++;
    if (an_n !== 4'b1011 || cur_digit !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_drive: an_n=%b cur=%0d, required 1011 2", an_n, cur_digit);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an_n !== 4'hF || nibble !== 4'h0 || cur_digit !== 2'd0 || slot_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: an_n=%b nibble=%h cur=%0d tick=%b, required 1111 0 0 0",
               an_n, nibble, cur_digit, slot_tick);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (an_n !== 4'hF || cur_digit !== 2'd0 || slot_tick !== 1'b0) begin
        errors++;
        $display("FAIL restart_dark k=%0d: an_n=%b cur=%0d tick=%b, required 1111 0 0",
                 k, an_n, cur_digit, slot_tick);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_slot(2'((i + 1) % 4), 4'h0, ~(4'b0001 << ((i + 1) % 4)));
      capture_slot(s);
      checks++;
      if (s !== e) begin
        errors++;
        $display("FAIL reset_cleared slot %0d: got %s, required %s", i, fmt_slot(s), fmt_slot(e));
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at 50us, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_basic_scan();
    test_lz_blank();
    test_disabled_digit();
    test_write_collision();
    test_reset_mid_drive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
